hex_byte_capture: RTL and testbench
===================================

# hex_byte_capture

Capture and activity-indicator stage feeding the 7-segment hex digit drivers. Accepts bytes from the SPI receive path via a valid strobe and holds the most recent bytes as a shift register of nibbles, one nibble per display digit. Drives the per-digit decimal-point line as an activity blinker, and keeps a saturating received-byte count.

## Interface
- NUM_DIGITS, 4: displayed nibbles; must be even and ≥2.
- BLINK_DIV, 12_500_000: cycles per dot half-period while active; ≥1.
- ACT_TIMEOUT, 50_000_000: cycles the block stays ACTIVE after the last accepted byte; ≥1.
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- byte_valid  in  1  one-cycle strobe; byte_data is accepted on every cycle it is high.
- byte_data  in  8  received byte.
- clear  in  1  synchronous clear of digits, count and state.
- freeze  in  1  when high, accepted bytes are counted but do not alter digits.
- digits  out  4*NUM_DIGITS  nibble i = digits[4i+3:4i]; digit 0 is the least-significant nibble of the newest byte.
- dot_n  out  1  decimal-point drive, active-low (0 = lit).
- byte_count  out  16  accepted-byte count, saturating at 0xFFFF.
- active  out  1  high in ACTIVE state.

## Operation
- Reset (async assert, sync-safe release): digits=0, byte_count=0, dot_n=1, active=0, state IDLE, all internal counters 0.
- Byte accept (byte_valid=1, clear=0): byte_count += 1 unless already 0xFFFF; if freeze=0, digits <= {digits[4*NUM_DIGITS-9:0], byte_data}, i.e. shift left by 8 with the new byte in the low byte; the oldest byte is discarded.
- clear=1: digits=0, byte_count=0, state IDLE, dot_n=1, counters 0; clear wins over a same-cycle byte_valid, and that byte is dropped and not counted.
- freeze does not affect the state machine: a frozen accept still triggers ACTIVE and reloads the timeout.
- State machine, two states:
  - IDLE: dot_n=1, active=0. On accept, go to ACTIVE; set blink counter to 0, dot_n to 0 and timeout counter to ACT_TIMEOUT-1.
  - ACTIVE: active=1.
    - Blink counter increments each cycle. When it reaches BLINK_DIV-1, it wraps to 0 and dot_n toggles.
    - An accept reloads the timeout counter to ACT_TIMEOUT-1 and leaves the blink phase unchanged.
    - With no accept, the timeout counter decrements. A cycle with the counter at 0 and no accept moves the block to IDLE, with dot_n=1 on the next cycle.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. byte_count is exactly 16 bits.

## Timing
- All outputs are registered. digits, byte_count, active and dot_n reflect an accept on the cycle after the byte_valid edge, with 1-cycle latency.
- Back-to-back byte_valid (every cycle) is accepted at full rate with no gaps or drops.
- ACTIVE persists exactly ACT_TIMEOUT cycles after the last accept cycle, then returns to IDLE. With ACT_TIMEOUT=1, a single byte gives exactly one ACTIVE cycle.
- Blink in ACTIVE: dot_n=0 for the first BLINK_DIV cycles, then alternates every BLINK_DIV cycles.
- Reset asserted mid-ACTIVE forces all reset values immediately, without waiting for a clock edge.
- Saturation: an accept at byte_count=0xFFFF leaves the count at 0xFFFF; digits and state update normally.

## Test plan
- Bench parameters: NUM_DIGITS=4, BLINK_DIV=4, ACT_TIMEOUT=16.
- Reset, then bytes 0x12, 0x34, 0x56 on consecutive cycles → one cycle after each: digits=0x0012, 0x1234, 0x3456; byte_count=3; active=1; dot_n=0.
- Single byte 0xAB then idle → dot_n pattern 0000 1111 0000 1111 over 16 ACTIVE cycles; active falls 16 cycles after the accept cycle; dot_n=1 thereafter.
- freeze=1 with byte 0xCD from digits=0x3456 → digits stay 0x3456; byte_count increments; active=1. clear=1 with byte_valid=1 in the same cycle → digits=0, byte_count=0, active=0.
- Byte every 10 cycles for 100 cycles → active stays 1 throughout and blink phase is never reset; active falls 16 cycles after the final byte.
- Preload byte_count to 0xFFFE by 65534 accepts, then 3 more bytes 0x01, 0x02, 0x03 → byte_count stays 0xFFFF and digits=0x0203. Assert reset_n=0 mid-ACTIVE → outputs return to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/hex_byte_capture_if.sv
// hex_byte_capture_if: byte strobe/control in, display digits/dot/count/activity out
interface hex_byte_capture_if #(parameter int NUM_DIGITS = 4);
  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    clear;
  logic                    freeze;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    dot_n;
  logic [15:0]             byte_count;
  logic                    active;
  modport master (
    output byte_valid, byte_data, clear, freeze,
    input  digits, dot_n, byte_count, active
  );
  modport slave (
    input  byte_valid, byte_data, clear, freeze,
    output digits, dot_n, byte_count, active
  );
endinterface

// File: rtl/hex_byte_capture.sv
// hex_byte_capture: nibble shift register for hex digits, blinking activity dot, saturating byte count
module hex_byte_capture #(
  parameter int NUM_DIGITS  = 4,
  parameter int BLINK_DIV   = 12_500_000,
  parameter int ACT_TIMEOUT = 50_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  hex_byte_capture_if.slave bus
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int TW = ACT_TIMEOUT > 1 ? $clog2(ACT_TIMEOUT) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TMO_LOAD   = TW'(ACT_TIMEOUT - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [15:0]     count_q, count_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            dot_n_q, dot_n_d;
  logic            accept;
  assign accept = bus.byte_valid & ~bus.clear;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      digits_q <= '0;
      count_q  <= '0;
      blink_q  <= '0;
      tmo_q    <= '0;
      dot_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      blink_q  <= blink_d;
      tmo_q    <= tmo_d;
      dot_n_q  <= dot_n_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    blink_d  = blink_q;
    tmo_d    = tmo_q;
    dot_n_d  = dot_n_q;
    if (accept) begin
      count_d = &count_q ? count_q : count_q + 16'd1;
      // truncating the concatenation drops the oldest byte
      if (!bus.freeze) digits_d = DW'({digits_q, bus.byte_data});
    end
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = ACTIVE;
        blink_d = '0;
        dot_n_d = 1'b0;
        tmo_d   = TMO_LOAD;
      end
    end else begin
      blink_d = blink_q == BLINK_LAST ? '0 : blink_q + 1'b1;
      dot_n_d = blink_q == BLINK_LAST ? ~dot_n_q : dot_n_q;
      if (accept) tmo_d = TMO_LOAD;
      else if (tmo_q == '0) begin
        state_d = IDLE;
        dot_n_d = 1'b1;
        blink_d = '0;
      end else tmo_d = tmo_q - 1'b1;
    end
    if (bus.clear) begin
      state_d  = IDLE;
      digits_d = '0;
      count_d  = '0;
      blink_d  = '0;
      tmo_d    = '0;
      dot_n_d  = 1'b1;
    end
  end
  assign bus.digits     = digits_q;
  assign bus.byte_count = count_q;
  assign bus.dot_n      = dot_n_q;
  assign bus.active     = state_q == ACTIVE;
endmodule

// File: tb/tb_hex_byte_capture.sv
// tb_hex_byte_capture: random and directed stimulus against a cycle-indexed behavioural model
module tb_hex_byte_capture;
  localparam int ND = 4;
  localparam int B  = 4;
  localparam int T  = 16;
  logic clk = 0;
  logic reset_n = 1;
  always #5 clk = ~clk;
  hex_byte_capture_if #(.NUM_DIGITS(ND)) bus ();
  hex_byte_capture #(.NUM_DIGITS(ND), .BLINK_DIV(B), .ACT_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  int total = 0;
  int bad = 0;
  int n = 0;
  logic [15:0] m_digits = '0;
  int m_count = 0;
  bit m_has = 0;
  int m_last = 0;
  int m_start = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask
  function automatic bit m_active_at(input int c);
    return m_has && (c - m_last) < T;
  endfunction
  task automatic check_all(input string tag);
    bit act;
    act = m_active_at(n);
    check({tag, ".digits"}, 32'(bus.digits), 32'(m_digits));
    check({tag, ".count"}, 32'(bus.byte_count), 32'(m_count));
    check({tag, ".active"}, 32'(bus.active), 32'(act));
    check({tag, ".dot_n"}, 32'(bus.dot_n), act ? 32'(((n - m_start) / B) % 2) : 32'd1);
  endtask
  task automatic step(input string tag, input bit v, input logic [7:0] d, input bit clr, input bit frz);
    bit was;
    bus.byte_valid = v;
    bus.byte_data  = d;
    bus.clear      = clr;
    bus.freeze     = frz;
    @(posedge clk);
    n++;
    was = m_active_at(n - 1);
    if (clr) begin
      m_digits = '0;
      m_count  = 0;
      m_has    = 0;
    end else if (v) begin
      if (m_count < 65535) m_count++;
      if (!frz) m_digits = {m_digits[7:0], d};
      if (!was) m_start = n;
      m_has  = 1;
      m_last = n;
    end
    #1 check_all(tag);
  endtask
  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag, 0, 8'h00, 0, 0);
  endtask
  initial begin
    bus.byte_valid = 0;
    bus.byte_data  = '0;
    bus.clear      = 0;
    bus.freeze     = 0;
    #2 reset_n = 0;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) reset_n = 1;
    step("b12", 1, 8'h12, 0, 0);
    step("b34", 1, 8'h34, 0, 0);
    step("b56", 1, 8'h56, 0, 0);
    step("frzcd", 1, 8'hCD, 0, 1);
    step("clrv", 1, 8'hEE, 1, 0);
    step("bab", 1, 8'hAB, 0, 0);
    idle("blink", 20);
    for (int i = 0; i < 10; i++) begin
      step("every10", 1, 8'($urandom), 0, 0);
      idle("every10", 9);
    end
    idle("tail", 20);
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);
    step("preclr", 0, 8'h00, 1, 0);
    for (int i = 0; i < 65534; i++) step("preload", 1, 8'($urandom), 0, $urandom_range(0, 1) == 1);
    step("s01", 1, 8'h01, 0, 0);
    step("s02", 1, 8'h02, 0, 0);
    step("s03", 1, 8'h03, 0, 0);
    check("sat.count", 32'(bus.byte_count), 32'h0000FFFF);
    check("sat.digits", 32'(bus.digits), 32'h00000203);
    idle("mid", 3);
    #2 reset_n = 0;
    m_digits = '0;
    m_count  = 0;
    m_has    = 0;
    #1 check_all("async_rst");
    @(negedge clk) reset_n = 1;
    step("post_rst", 1, 8'h9F, 0, 0);
    idle("post_rst", 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
